// File: rtl/baud_tick_gen.sv
// Run-time programmable baud tick generator: bit-period tick, mid-bit sample tick,
// and a fractional accumulator that stretches some periods by one cycle.
module baud_tick_gen #(
  parameter int CNT_W        = 14,
  parameter int FRAC_W       = 8,
  parameter int DEFAULT_DIV  = 10417,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              baud_tick,
  output logic              mid_tick,
  output logic [CNT_W-1:0]  counter,
  output logic              cfg_err
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic              baud_q, baud_d;
  logic              mid_q, mid_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  div_eff;
  logic [CNT_W-1:0]  mid_pt;
  logic [CNT_W:0]    term;
  logic [FRAC_W:0]   acc_sum;
  logic              wrap;

  // Divisors below 2 leave no room for a distinct mid point, so clamp them.
  assign div_eff = (div_q < CNT_W'(2)) ? CNT_W'(2) : div_q;
  assign mid_pt  = div_eff >> 1;
  // One extra bit keeps div_eff + ext from overflowing before the -1.
  assign term    = {1'b0, div_eff} + {{CNT_W{1'b0}}, ext_q} - (CNT_W+1)'(1);
  assign wrap    = ({1'b0, cnt_q} == term);
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    frac_d = frac_q;
    acc_d  = acc_q;
    ext_d  = ext_q;
    baud_d = 1'b0;
    mid_d  = 1'b0;
    err_d  = (div_q < CNT_W'(2));
    if (restart) begin
      cnt_d  = '0;
      acc_d  = '0;
      ext_d  = 1'b0;
      div_d  = div_int;
      frac_d = div_frac;
    end else if (en) begin
      if (wrap) begin
        // Carry uses the fraction of the period just ending, before the shadow load.
        cnt_d  = '0;
        baud_d = 1'b1;
        acc_d  = acc_sum[FRAC_W-1:0];
        ext_d  = acc_sum[FRAC_W];
        div_d  = div_int;
        frac_d = div_frac;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        mid_d = ((cnt_q + CNT_W'(1)) == mid_pt);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= CNT_W'(DEFAULT_DIV);
      frac_q <= FRAC_W'(DEFAULT_FRAC);
      acc_q  <= '0;
      ext_q  <= 1'b0;
      baud_q <= 1'b0;
      mid_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      frac_q <= frac_d;
      acc_q  <= acc_d;
      ext_q  <= ext_d;
      baud_q <= baud_d;
      mid_q  <= mid_d;
      err_q  <= err_d;
    end
  end

  assign baud_tick = baud_q;
  assign mid_tick  = mid_q;
  assign counter   = cnt_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: expected tick cycles are queued by each
// scenario and matched against ticks captured by a negedge monitor.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic [13:0] div_int = 14'd10417;
  logic [7:0]  div_frac = 8'h00;
  logic        baud_tick;
  logic        mid_tick;
  logic [13:0] counter;
  logic        cfg_err;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int obs_b[$], obs_bc[$], obs_m[$], obs_mc[$];
  int exp_b[$], exp_m[$], exp_mc[$];

  baud_tick_gen #(
    .CNT_W(14), .FRAC_W(8), .DEFAULT_DIV(10417), .DEFAULT_FRAC(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .div_int(div_int), .div_frac(div_frac),
    .baud_tick(baud_tick), .mid_tick(mid_tick),
    .counter(counter), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (baud_tick) begin obs_b.push_back(cyc); obs_bc.push_back(int'(counter)); end
      if (mid_tick)  begin obs_m.push_back(cyc); obs_mc.push_back(int'(counter)); end
    end
  end

  task automatic clear_obs();
    obs_b.delete(); obs_bc.delete(); obs_m.delete(); obs_mc.delete();
    exp_b.delete(); exp_m.delete(); exp_mc.delete();
  endtask

  // Called at a negedge; r is the edge number on which restart is sampled.
  task automatic do_restart(output int r);
    restart = 1'b1;
    r = cyc + 1;
    @(negedge clk);
    restart = 1'b0;
    clear_obs();
  endtask

  // Reference model of the tick timeline from a restart at edge r.
  task automatic push_model(input int r, input int dv, input int fr, input int n);
    int t, acc, ext, de;
    t = r; acc = 0; ext = 0;
    de = (dv < 2) ? 2 : dv;
    for (int k = 0; k < n; k++) begin
      exp_m.push_back(t + de / 2); exp_mc.push_back(de / 2);
      t = t + de + ext;
      exp_b.push_back(t);
      acc = acc + fr;
      ext = (acc >= 256) ? 1 : 0;
      acc = acc % 256;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (baud_tick !== 1'b0) begin failures++; $display("FAIL reset_baud got=%0b exp=0", baud_tick); end
    checks++; if (mid_tick !== 1'b0) begin failures++; $display("FAIL reset_mid got=%0b exp=0", mid_tick); end
    checks++; if (counter !== 14'd0) begin failures++; $display("FAIL reset_counter got=%0d exp=0", counter); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%0b exp=0", cfg_err); end
  endtask

  task automatic test_default_and_div_change();
    int base, e, o, c, ec;
    en = 1'b1; div_int = 14'd10417; div_frac = 8'h00;
    rst = 1'b0;
    base = cyc;
    clear_obs();
    exp_b = '{base + 10417, base + 20834, base + 20854, base + 20874};
    exp_m = '{base + 5208, base + 15625, base + 20844, base + 20864};
    exp_mc = '{5208, 5208, 10, 10};
    for (int i = 0; i < 21000 && obs_b.size() < 4; i++) begin
      @(negedge clk);
      if (cyc == base + 15417) div_int = 14'd20;
    end
    checks++; if (obs_b.size() < 4 || obs_m.size() < 4) begin failures++; $display("FAIL default_timeout got=%0d exp=4", obs_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); c = obs_bc.pop_front();
      checks++; if (o !== e || c !== 0) begin failures++; $display("FAIL default_tick got=cyc%0d/cnt%0d exp=cyc%0d/cnt0", o - base, c, e - base); end
    end
    while (exp_m.size() > 0 && obs_m.size() > 0) begin
      e = exp_m.pop_front(); ec = exp_mc.pop_front(); o = obs_m.pop_front(); c = obs_mc.pop_front();
      checks++; if (o !== e || c !== ec) begin failures++; $display("FAIL default_mid got=cyc%0d/cnt%0d exp=cyc%0d/cnt%0d", o - base, c, e - base, ec); end
    end
  endtask

  task automatic test_restart_mid_period();
    int r, n, e, o, c;
    div_int = 14'd10417;
    do_restart(r);
    n = 0;
    while (counter !== 14'd3000 && n < 3100) begin @(negedge clk); n++; end
    checks++; if (counter !== 14'd3000) begin failures++; $display("FAIL restart_reach got=%0d exp=3000", counter); end
    do_restart(r);
    checks++; if (counter !== 14'd0 || baud_tick !== 1'b0) begin failures++; $display("FAIL restart_clear got=cnt%0d/tick%0b exp=cnt0/tick0", counter, baud_tick); end
    exp_b.push_back(r + 10417);
    n = 0;
    while (obs_b.size() < 1 && n < 10500) begin @(negedge clk); n++; end
    checks++; if (obs_b.size() < 1) begin failures++; $display("FAIL restart_timeout got=%0d exp=1", obs_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); c = obs_bc.pop_front();
      checks++; if (o !== e || c !== 0) begin failures++; $display("FAIL restart_tick got=%0d/cnt%0d exp=%0d/cnt0", o - r, c, e - r); end
    end
  endtask

  task automatic test_en_hold();
    int r, n, e, o, c;
    div_int = 14'd200; div_frac = 8'h00;
    do_restart(r);
    exp_b.push_back(r + 250);
    exp_m.push_back(r + 100);
    n = 0;
    while (counter !== 14'd100 && n < 300) begin @(negedge clk); n++; end
    en = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (counter !== 14'd100) begin failures++; $display("FAIL en_hold_counter got=%0d exp=100", counter); end
    en = 1'b1;
    n = 0;
    while (obs_b.size() < 1 && n < 400) begin @(negedge clk); n++; end
    checks++; if (obs_b.size() < 1 || obs_m.size() < 1) begin failures++; $display("FAIL en_hold_timeout got=%0d exp=1", obs_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); c = obs_bc.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL en_hold_tick got=%0d exp=%0d", o - r, e - r); end
    end
    while (exp_m.size() > 0 && obs_m.size() > 0) begin
      e = exp_m.pop_front(); o = obs_m.pop_front(); c = obs_mc.pop_front();
      checks++; if (o !== e || c !== 100) begin failures++; $display("FAIL en_hold_mid got=%0d/cnt%0d exp=%0d/cnt100", o - r, c, e - r); end
    end
  endtask

  task automatic test_frac4();
    int r, n, e, o, c, ec;
    div_int = 14'd4; div_frac = 8'h80;
    do_restart(r);
    push_model(r, 4, 128, 7);
    n = 0;
    while (obs_b.size() < 7 && n < 100) begin @(negedge clk); n++; end
    checks++; if (obs_b.size() < 7 || obs_m.size() < 7) begin failures++; $display("FAIL frac4_timeout got=%0d exp=7", obs_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); c = obs_bc.pop_front();
      checks++; if (o !== e || c !== 0) begin failures++; $display("FAIL frac4_tick got=%0d/cnt%0d exp=%0d/cnt0", o - r, c, e - r); end
    end
    while (exp_m.size() > 0 && obs_m.size() > 0) begin
      e = exp_m.pop_front(); ec = exp_mc.pop_front(); o = obs_m.pop_front(); c = obs_mc.pop_front();
      checks++; if (o !== e || c !== ec) begin failures++; $display("FAIL frac4_mid got=%0d/cnt%0d exp=%0d/cnt%0d", o - r, c, e - r, ec); end
    end
  endtask

  // Any 256 consecutive periods after the first hold exactly 256*div + frac cycles.
  task automatic test_frac_rule();
    int r, n, span;
    div_int = 14'd4; div_frac = 8'hAB;
    do_restart(r);
    n = 0;
    while (obs_b.size() < 257 && n < 1400) begin @(negedge clk); n++; end
    checks++;
    if (obs_b.size() < 257) begin
      failures++; $display("FAIL frac_rule_timeout got=%0d exp=257", obs_b.size());
    end else begin
      span = obs_b[256] - obs_b[0];
      if (span !== 256 * 4 + 171) begin failures++; $display("FAIL frac_rule_span got=%0d exp=%0d", span, 256 * 4 + 171); end
    end
  endtask

  task automatic test_restart_on_wrap();
    int r, r2, n, e, o, c;
    div_int = 14'd4; div_frac = 8'h00;
    do_restart(r);
    repeat (3) @(negedge clk);
    restart = 1'b1;
    r2 = cyc + 1;
    @(negedge clk);
    restart = 1'b0;
    checks++; if (baud_tick !== 1'b0 || counter !== 14'd0) begin failures++; $display("FAIL wrap_restart got=tick%0b/cnt%0d exp=tick0/cnt0", baud_tick, counter); end
    clear_obs();
    exp_b.push_back(r2 + 4);
    n = 0;
    while (obs_b.size() < 1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (obs_b.size() < 1) begin failures++; $display("FAIL wrap_timeout got=%0d exp=1", obs_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); c = obs_bc.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL wrap_next_tick got=%0d exp=%0d", o - r2, e - r2); end
    end
  endtask

  task automatic test_cfg_err_and_async_reset();
    int r, n, e, o, c, ec;
    div_int = 14'd1; div_frac = 8'h00;
    do_restart(r);
    push_model(r, 1, 0, 3);
    @(negedge clk);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_set got=%0b exp=1", cfg_err); end
    n = 0;
    while (obs_b.size() < 3 && n < 20) begin @(negedge clk); n++; end
    checks++; if (obs_b.size() < 3 || obs_m.size() < 3) begin failures++; $display("FAIL cfg_timeout got=%0d exp=3", obs_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); c = obs_bc.pop_front();
      checks++; if (o !== e || c !== 0) begin failures++; $display("FAIL cfg_tick got=%0d/cnt%0d exp=%0d/cnt0", o - r, c, e - r); end
    end
    while (exp_m.size() > 0 && obs_m.size() > 0) begin
      e = exp_m.pop_front(); ec = exp_mc.pop_front(); o = obs_m.pop_front(); c = obs_mc.pop_front();
      checks++; if (o !== e || c !== ec) begin failures++; $display("FAIL cfg_mid got=%0d/cnt%0d exp=%0d/cnt%0d", o - r, c, e - r, ec); end
    end
    n = 0;
    while (counter !== 14'd1 && n < 4) begin @(negedge clk); n++; end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (baud_tick !== 1'b0 || mid_tick !== 1'b0 || counter !== 14'd0 || cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=tick%0b/mid%0b/cnt%0d/err%0b exp=all0", baud_tick, mid_tick, counter, cfg_err);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic test_frac_10416();
    int r, n, e, o, c;
    div_int = 14'd10416; div_frac = 8'hAB;
    do_restart(r);
    push_model(r, 10416, 171, 3);
    n = 0;
    while (obs_b.size() < 3 && n < 31300) begin @(negedge clk); n++; end
    checks++; if (obs_b.size() < 3) begin failures++; $display("FAIL frac_ab_timeout got=%0d exp=3", obs_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); c = obs_bc.pop_front();
      checks++; if (o !== e || c !== 0) begin failures++; $display("FAIL frac_ab_tick got=%0d/cnt%0d exp=%0d/cnt0", o - r, c, e - r); end
    end
  endtask

  initial begin
    test_reset();
    test_default_and_div_change();
    test_restart_mid_period();
    test_en_hold();
    test_frac4();
    test_frac_rule();
    test_restart_on_wrap();
    test_cfg_err_and_async_reset();
    test_frac_10416();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
Parametrised successor to the fixed-divide baud rate generator. It produces a one-cycle bit-period tick and a mid-bit sample tick from a run-time divisor. An optional fractional accumulator removes the long-term rate error of integer division, for example 100 MHz / 9600 = 10416.67. It sits between the system clock and the UART receiver/transmitter bit FSMs; restart aligns the bit grid to a detected start edge.

Parameters:
CNT_W, 14, width of the integer divisor and of the cycle counter
FRAC_W, 8, width of the fractional divisor and accumulator
DEFAULT_DIV, 10417, integer period (cycles) loaded at reset
DEFAULT_FRAC, 0, fractional period (units of 2^-FRAC_W cycle) loaded at reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  count enable; low holds all state
restart  in  1  synchronous realign: clear counter/accumulator and load divisor
div_int  in  CNT_W  integer bit period in cycles; values <2 are clamped to 2
div_frac  in  FRAC_W  fractional bit period
baud_tick  out  1  registered one-cycle pulse at each bit-period boundary
mid_tick  out  1  registered one-cycle pulse at mid-period
counter  out  CNT_W  current cycle count within the period
cfg_err  out  1  registered; high while the latched div_int is <2

Behaviour:
- Reset (async) state: counter=0, acc=0, ext=0, div_q=DEFAULT_DIV, frac_q=DEFAULT_FRAC; baud_tick, mid_tick and cfg_err are all 0.
- Effective period: P = max(div_q,2) + ext. Terminal count: T = P-1. Mid point: H = max(div_q,2)>>1.
- Shadow load of div_q<=div_int and frac_q<=div_frac happens only at a wrap or a restart. Changes to div_int/div_frac mid-period have no effect on the current period.
- Priority order: rst > restart > en.
- Restart: counter<=0, acc<=0, ext<=0, shadow load. baud_tick and mid_tick are 0 on that edge. Restart coinciding with a wrap means restart wins and no tick is issued.
- en=0: counter, acc, ext and the shadow registers hold; both ticks deassert on the next edge.
- en=1, counter!=T: counter<=counter+1.
  - mid_tick<=1 on the edge where counter becomes H; otherwise 0.
- en=1, counter==T (wrap):
  - counter<=0 and baud_tick<=1.
  - {carry,acc}<=acc+frac_q, using the old frac_q before the shadow load; ext<=carry.
  - Shadow load occurs.
  - baud_tick is high for exactly one cycle, visible while counter reads 0.
- Latency: after rst release with en=1 and default divisor, baud_tick is first high in the cycle after the 10417th rising edge, then repeats every 10417 cycles.
- Fraction zero: the period is fixed at div_q; ext is never set.
- Fractional period rule: over 2^FRAC_W periods, the cycle total equals 2^FRAC_W*div_q + frac_q exactly (fixed divisor, no restart).
- cfg_err<=(div_q<2), updated every cycle.
- Width rule: counter never exceeds div_q, which always fits CNT_W. The adder for acc+frac_q is FRAC_W+1 bits wide.

Test Plan:
- Default parameters, en=1 held, no restart: baud_tick high only after edges 10417, 20834 and 31251; mid_tick after edges 5208 and 15625; counter=0 during each baud_tick.
- div_int=4, div_frac=0x80, restart pulse then en=1: periods between baud_ticks are 4,4,5,4,5,4,5 cycles; mid_tick occurs on counter==2 each period.
- div_int=10416, div_frac=0xAB: the first five periods are 10416, 10416, 10417, 10417, 10416; over 256 periods the total is 256*10416+171 cycles.
- Mid-period changes:
  - Restart at counter=3000: the next baud_tick comes exactly P cycles later.
  - en low for 50 cycles at counter=100: the tick is delayed by 50 cycles; no ticks occur while en is low.
- div_int changed 10417->20 at counter=5000: the current period still ends at 10417; following periods are 20 cycles.
- div_int=1 loaded via restart: cfg_err=1 and the period behaves as 2 cycles. Assert rst mid-count: all outputs are 0 immediately, without waiting for a clock edge.
